// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers.
// Each grant is held until the transmitter reports completion or a watchdog expires.
module uart_tx_arbiter #(
    parameter int unsigned  NUM_REQ        = 4,
    parameter int unsigned  DATA_W         = 8,
    parameter int unsigned  TIMEOUT_CYCLES = 2604,
    parameter int unsigned  GAP_CYCLES     = 2,
    localparam int unsigned ID_W           = $clog2(NUM_REQ)
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ*DATA_W-1:0] i_data,
    output logic [NUM_REQ-1:0]        o_ack,
    output logic                      o_tx_dr,
    output logic [DATA_W-1:0]         o_tx_data,
    input  logic                      i_tx_done,
    output logic                      o_busy,
    output logic [ID_W-1:0]           o_grant_id,
    output logic                      o_timeout
);

    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DONE,
        GAP
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic                tx_dr_q, tx_dr_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                busy_q, busy_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;
    logic                timeout_q, timeout_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic [GAP_W-1:0]    gap_q, gap_d;

    logic                req_found;
    logic [ID_W-1:0]     win_id;
    logic [ID_W-1:0]     idx_w;
    int unsigned         idx;

    // The last grantee doubles as the round-robin pointer; search starts just above it.
    always_comb begin
        req_found = 1'b0;
        win_id    = grant_id_q;
        idx       = 0;
        idx_w     = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx   = (32'(grant_id_q) + i) % NUM_REQ;
            idx_w = ID_W'(idx);
            if (!req_found && i_req[idx_w]) begin
                req_found = 1'b1;
                win_id    = idx_w;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ack_d      = '0;
        tx_dr_d    = 1'b0;
        tx_data_d  = tx_data_q;
        grant_id_d = grant_id_q;
        timeout_d  = 1'b0;
        wd_d       = wd_q;
        gap_d      = gap_q;

        case (state_q)
            IDLE: begin
                if (req_found) begin
                    ack_d[win_id] = 1'b1;
                    tx_dr_d       = 1'b1;
                    tx_data_d     = i_data[32'(win_id)*DATA_W +: DATA_W];
                    grant_id_d    = win_id;
                    wd_d          = '0;
                    state_d       = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // wd_q counts cycles since the strobe; a done seen during the strobe
                // cycle (tx_dr_q high) belongs to the previous frame.
                wd_d = wd_q + WD_W'(1);
                if (!tx_dr_q && i_tx_done) begin
                    state_d = GAP;
                    gap_d   = '0;
                end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = GAP;
                    gap_d     = '0;
                end
            end
            GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            ack_q      <= '0;
            tx_dr_q    <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
            grant_id_q <= ID_W'(NUM_REQ - 1);
            timeout_q  <= 1'b0;
            wd_q       <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            tx_dr_q    <= tx_dr_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            grant_id_q <= grant_id_d;
            timeout_q  <= timeout_d;
            wd_q       <= wd_d;
            gap_q      <= gap_d;
        end
    end

    assign o_ack      = ack_q;
    assign o_tx_dr    = tx_dr_q;
    assign o_tx_data  = tx_data_q;
    assign o_busy     = busy_q;
    assign o_grant_id = grant_id_q;
    assign o_timeout  = timeout_q;

endmodule
